uart_core: RTL and testbench
============================

// Module: uart_core
// PURPOSE
// - Buffered full-duplex UART: TX/RX FIFOs, 16x-oversampled mid-bit RX sampling, runtime frame config.
// - Successor to the fixed-8-bit, unbuffered transceiver: parametrised width/depth, error reporting, valid/ready host side.
// - Sits between an SoC bus adapter (host side) and the txd/rxd pads.
// PARAMETERS
// - DATA_W    9   max data bits per frame (5..9)
// - TX_DEPTH  16  TX FIFO entries (power of 2, >=2)
// - RX_DEPTH  16  RX FIFO entries (power of 2, >=2)
// PORTS
// - clk_i          in   1           single clock
// - rst_i          in   1           asynchronous, active-low reset
// - baud_div_i     in   16          oversample tick every baud_div_i+1 clocks
// - len_i          in   4           data bits; <5 -> 5, >DATA_W -> DATA_W
// - parity_en_i    in   1           parity bit enabled
// - parity_odd_i   in   1           1 = odd, 0 = even
// - stop2_i        in   1           TX sends 2 stop bits
// - loop_i         in   1           internal loopback (see CONFIGURATION)
// - tx_valid_i     in   1           host write strobe
// - tx_data_i      in   DATA_W      write data, LSB first on line
// - tx_ready_o     out  1           TX FIFO not full
// - rx_valid_o     out  1           RX FIFO not empty
// - rx_data_o      out  DATA_W      RX FIFO head, first-word fall-through; unused MSBs 0
// - rx_ready_i     in   1           host read strobe
// - tx_level_o     out  clog2(TX_DEPTH)+1  TX FIFO occupancy
// - rx_level_o     out  clog2(RX_DEPTH)+1  RX FIFO occupancy
// - tx_busy_o      out  1           TX FSM not IDLE
// - err_parity_o   out  1           sticky error flags, cleared by err_clr_i
// - err_frame_o    out  1
// - err_overrun_o  out  1
// - err_clr_i      in   1           clear-all; a set in the same cycle wins
// - rxd_i          in   1           serial in (async, 2-flop synchronised, sync reset value 1)
// - txd_o          out  1           serial out
// BEHAVIOUR
// - Reset: txd_o=1, tx_ready_o=1, rx_valid_o=0, levels=0, tx_busy_o=0, all err_*=0, FIFOs empty, FSMs IDLE, tick counter 0.
// - Reset mid-frame aborts the frame at once: txd_o=1 asynchronously; partial RX frame discarded.
// - Tick: counter 0..baud_div_i, tick pulses one cycle on wrap; baud_div_i=0 gives a tick every clock. One bit = 16 ticks.
// - Config (len, parity, stop2) latched at frame start (TX pop / RX start detect); mid-frame changes do not affect the current frame.
// - FIFO handshake: push when tx_valid_i&&tx_ready_o; pop when rx_valid_o&&rx_ready_i.
// - FIFO occupancy: simultaneous push+pop keeps the level unchanged.
// - TX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   - Leaves IDLE on a tick with FIFO non-empty: pops and drives txd_o=0 that cycle.
//   - STOP lasts 16 or 32 ticks; back-to-back frames need no idle gap.
// - RX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   - Start detect: synced rxd=0 on a tick. Re-checked after 8 ticks; if 1, false start -> IDLE.
//   - Later bits sampled every 16 ticks (mid-bit). RX checks one stop bit only.
// - Parity error: word still pushed, err_parity_o set.
// - Frame error (stop sample 0): word discarded, err_frame_o set; FSM waits for rxd=1 before IDLE.
// - Overrun: push while RX FIFO full and no same-cycle pop drops the new word and sets err_overrun_o; FIFO contents intact.
// - Error flags assert the cycle after the stop-bit sample.
// CONFIGURATION
// - UART_LOOPBACK_EN defined: loop_i=1 routes txd into the RX synchroniser input instead of rxd_i; txd_o still driven.
// - UART_LOOPBACK_EN undefined: loop_i is ignored and the RX path always uses rxd_i.
// STRUCTURE
// - Package uart_pkg: tx_state_e, rx_state_e enums; OVERSAMPLE=16; MIN_LEN=5; function parity_calc(data, len, odd).
// - Sub-module uart_sync_fifo #(W, DEPTH): FWFT, count output; instantiated for TX and RX.
// - Tick generator and both FSMs stay in uart_core.
// TESTING
// - Loopback TX/RX:
//   - Stimulus: loop_i=1, baud_div=0, 8N1, write 0xA5.
//   - Response: txd_o = 0,1,0,1,0,0,1,0,1,1, each 16 clk; rx_data_o=0xA5, rx_valid_o=1 about 160 clk after pop.
// - Parity:
//   - Stimulus: even parity, write 0x07.
//   - Response: parity bit 1. rxd_i frame 0x07 with parity 0 -> word delivered, err_parity_o=1; err_clr_i -> 0.
// - Glitch: rxd_i low for 5 ticks -> no rx_valid_o, no error.
// - Frame error: stop bit 0 on rxd_i -> err_frame_o=1, rx_level_o stays 0.
// - Overrun:
//   - Stimulus: 17 frames with rx_ready_i=0, RX_DEPTH=16.
//   - Response: rx_level_o=16, err_overrun_o=1, first 16 words read back in order.
// - TX full + reset:
//   - Stimulus: 16 writes while TX idle-blocked (baud_div max).
//   - Response: tx_ready_o=0 at level 16. Assert rst_i mid-frame -> txd_o=1, levels 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and the parity helper for the buffered UART.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MIN_LEN    = 5;
  localparam int MAX_W      = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // RX_BREAK holds the receiver after a bad stop bit until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // Parity over the low 'len' bits; odd=1 makes the total count of ones odd.
  function automatic logic parity_calc(input logic [MAX_W-1:0] data,
                                       input logic [3:0]       len,
                                       input logic             odd);
    logic p;
    p = odd;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(len)) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Pushes into a full FIFO are accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == {(AW+1){1'b0}});
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign rdata_o   = mem_q[rd_q];
  assign count_o   = cnt_q;

  // Next occupancy: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_q <= wr_q + AW'(1);
      if (do_pop_s)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_core.sv
// Buffered full-duplex UART: TX/RX FIFOs, 16x oversampled receiver, runtime
// frame format. Optional build macro UART_LOOPBACK_EN enables loop_i, which
// feeds txd back into the receiver instead of rxd_i.
module uart_core #(
  parameter int DATA_W   = 9,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [15:0]                   baud_div_i,
  input  logic [3:0]                    len_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          loop_i,
  input  logic                          tx_valid_i,
  input  logic [DATA_W-1:0]             tx_data_i,
  output logic                          tx_ready_o,
  output logic                          rx_valid_o,
  output logic [DATA_W-1:0]             rx_data_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(TX_DEPTH):0]     tx_level_o,
  output logic [$clog2(RX_DEPTH):0]     rx_level_o,
  output logic                          tx_busy_o,
  output logic                          err_parity_o,
  output logic                          err_frame_o,
  output logic                          err_overrun_o,
  input  logic                          err_clr_i,
  input  logic                          rxd_i,
  output logic                          txd_o
);
  import uart_pkg::*;

  // ---------------- oversample tick ----------------
  logic [15:0] tick_cnt_q;
  logic        tick_s;

  // Compare with >= so lowering baud_div_i mid-count takes effect immediately.
  assign tick_s = (tick_cnt_q >= baud_div_i);

  // Free-running tick counter, wrapping at baud_div_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      tick_cnt_q <= 16'd0;
    else if (tick_s) tick_cnt_q <= 16'd0;
    else             tick_cnt_q <= tick_cnt_q + 16'd1;
  end

  // Effective word length, clamped to MIN_LEN..DATA_W.
  logic [3:0] len_eff_s;
  always_comb begin
    len_eff_s = len_i;
    if (len_i < 4'(MIN_LEN))     len_eff_s = 4'(MIN_LEN);
    else if (len_i > 4'(DATA_W)) len_eff_s = 4'(DATA_W);
    else                         len_eff_s = len_i;
  end

  // ---------------- TX path ----------------
  tx_state_e         tx_state_q;
  logic [3:0]        tx_tick_q;
  logic [3:0]        tx_bit_q;
  logic [3:0]        tx_len_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              tx_pen_q;
  logic              tx_par_q;
  logic              tx_stop2_q;
  logic              tx_stop_two_q;
  logic              txd_q;
  logic [DATA_W-1:0] tx_head_s;
  logic              tx_full_s;
  logic              tx_empty_s;
  logic              tx_push_s;
  logic              tx_pop_s;
  logic              tx_last_stop_s;

  assign tx_push_s      = tx_valid_i && !tx_full_s;
  assign tx_last_stop_s = (tx_state_q == TX_STOP) && (tx_tick_q == 4'd15) &&
                          (!tx_stop2_q || tx_stop_two_q);
  // A new frame starts from IDLE or directly at the end of the last stop bit.
  assign tx_pop_s       = tick_s && !tx_empty_s &&
                          ((tx_state_q == TX_IDLE) || tx_last_stop_s);

  uart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push_s),
    .wdata_i (tx_data_i),
    .pop_i   (tx_pop_s),
    .rdata_o (tx_head_s),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s),
    .count_o (tx_level_o)
  );

  // TX FSM: shifts start, data (LSB first), optional parity and stop bits onto txd.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_state_q    <= TX_IDLE;
      tx_tick_q     <= 4'd0;
      tx_bit_q      <= 4'd0;
      tx_len_q      <= 4'(MIN_LEN);
      tx_shift_q    <= {DATA_W{1'b0}};
      tx_pen_q      <= 1'b0;
      tx_par_q      <= 1'b0;
      tx_stop2_q    <= 1'b0;
      tx_stop_two_q <= 1'b0;
      txd_q         <= 1'b1;
    end else if (tx_pop_s) begin
      tx_state_q    <= TX_START;
      tx_tick_q     <= 4'd0;
      tx_bit_q      <= 4'd0;
      tx_len_q      <= len_eff_s;
      tx_shift_q    <= tx_head_s;
      tx_pen_q      <= parity_en_i;
      tx_par_q      <= parity_calc(MAX_W'(tx_head_s), len_eff_s, parity_odd_i);
      tx_stop2_q    <= stop2_i;
      tx_stop_two_q <= 1'b0;
      txd_q         <= 1'b0;
    end else if (tick_s) begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_tick_q <= 4'd0;
          txd_q     <= 1'b1;
        end
        TX_START: begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            tx_state_q <= TX_DATA;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[DATA_W-1:1]};
          end
        end
        TX_DATA: begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            if (tx_bit_q == tx_len_q - 4'd1) begin
              tx_state_q <= tx_pen_q ? TX_PARITY : TX_STOP;
              txd_q      <= tx_pen_q ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[DATA_W-1:1]};
            end
          end
        end
        TX_PARITY: begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            tx_state_q <= TX_STOP;
            txd_q      <= 1'b1;
          end
        end
        TX_STOP: begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_last_stop_s)          tx_state_q    <= TX_IDLE;
          else if (tx_tick_q == 4'd15) tx_stop_two_q <= 1'b1;
        end
        default: begin
          tx_state_q <= TX_IDLE;
          txd_q      <= 1'b1;
        end
      endcase
    end
  end

  assign txd_o      = txd_q;
  assign tx_ready_o = !tx_full_s;
  assign tx_busy_o  = (tx_state_q != TX_IDLE);

  // ---------------- RX path ----------------
  logic rx_in_s;
`ifdef UART_LOOPBACK_EN
  assign rx_in_s = loop_i ? txd_q : rxd_i;
`else
  logic unused_loop_s;
  assign unused_loop_s = loop_i;
  assign rx_in_s       = rxd_i;
`endif

  logic rx_meta_q;
  logic rx_sync_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in_s;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e         rx_state_q;
  logic [3:0]        rx_tick_q;
  logic [3:0]        rx_bit_q;
  logic [3:0]        rx_len_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rx_pen_q;
  logic              rx_odd_q;
  logic              rx_par_q;
  logic [DATA_W-1:0] rx_word_s;
  logic [DATA_W-1:0] rx_head_s;
  logic              rx_full_s;
  logic              rx_empty_s;
  logic              rx_stop_smp_s;
  logic              rx_push_s;
  logic              rx_pop_s;
  logic              rx_par_err_s;
  logic              rx_frm_err_s;
  logic              rx_ovr_s;

  // Bits enter at the MSB end, so a short word is right-aligned by the remaining gap.
  assign rx_word_s     = rx_shift_q >> (4'(DATA_W) - rx_len_q);
  assign rx_stop_smp_s = tick_s && (rx_state_q == RX_STOP) && (rx_tick_q == 4'd15);
  assign rx_push_s     = rx_stop_smp_s && rx_sync_q;
  assign rx_frm_err_s  = rx_stop_smp_s && !rx_sync_q;
  assign rx_par_err_s  = rx_push_s && rx_pen_q &&
                         (rx_par_q != parity_calc(MAX_W'(rx_word_s), rx_len_q, rx_odd_q));
  assign rx_pop_s      = !rx_empty_s && rx_ready_i;
  assign rx_ovr_s      = rx_push_s && rx_full_s && !rx_pop_s;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push_s),
    .wdata_i (rx_word_s),
    .pop_i   (rx_pop_s),
    .rdata_o (rx_head_s),
    .full_o  (rx_full_s),
    .empty_o (rx_empty_s),
    .count_o (rx_level_o)
  );

  // RX FSM: start detect, half-bit recheck, then one sample per 16 ticks at mid-bit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 4'd0;
      rx_len_q   <= 4'(MIN_LEN);
      rx_shift_q <= {DATA_W{1'b0}};
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_par_q   <= 1'b0;
    end else if (rx_state_q == RX_BREAK) begin
      if (rx_sync_q) rx_state_q <= RX_IDLE;
    end else if (tick_s) begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_tick_q <= 4'd0;
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= {DATA_W{1'b0}};
            rx_len_q   <= len_eff_s;
            rx_pen_q   <= parity_en_i;
            rx_odd_q   <= parity_odd_i;
          end
        end
        RX_START: begin
          if (rx_tick_q == 4'd7) begin
            rx_tick_q  <= 4'd0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_q <= rx_tick_q + 4'd1;
          end
        end
        RX_DATA: begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_W-1:1]};
            if (rx_bit_q == rx_len_q - 4'd1) rx_state_q <= rx_pen_q ? RX_PARITY : RX_STOP;
            else                             rx_bit_q   <= rx_bit_q + 4'd1;
          end
        end
        RX_PARITY: begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_par_q   <= rx_sync_q;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) rx_state_q <= rx_sync_q ? RX_IDLE : RX_BREAK;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  logic err_par_q;
  logic err_frm_q;
  logic err_ovr_q;

  // Sticky error flags; a set in the same cycle as err_clr_i takes priority.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      if (rx_par_err_s)   err_par_q <= 1'b1;
      else if (err_clr_i) err_par_q <= 1'b0;
      if (rx_frm_err_s)   err_frm_q <= 1'b1;
      else if (err_clr_i) err_frm_q <= 1'b0;
      if (rx_ovr_s)       err_ovr_q <= 1'b1;
      else if (err_clr_i) err_ovr_q <= 1'b0;
    end
  end

  assign err_parity_o  = err_par_q;
  assign err_frame_o   = err_frm_q;
  assign err_overrun_o = err_ovr_q;
  assign rx_valid_o    = !rx_empty_s;
  assign rx_data_o     = rx_empty_s ? {DATA_W{1'b0}} : rx_head_s;

endmodule

// File: tb/tb_uart_core.sv
// Directed-random bench for uart_core with a frame-level reference model.
module tb_uart_core;

  localparam int DATA_W = 9;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [15:0]       baud_div_i;
  logic [3:0]        len_i;
  logic              parity_en_i, parity_odd_i, stop2_i, loop_i;
  logic              tx_valid_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_ready_o, rx_valid_o, rx_ready_i;
  logic [DATA_W-1:0] rx_data_o;
  logic [4:0]        tx_level_o, rx_level_o;
  logic              tx_busy_o, err_parity_o, err_frame_o, err_overrun_o, err_clr_i;
  logic              txd_o;
  logic              ext_loop, rxd_drv;
  logic              rxd_line;

  assign rxd_line = ext_loop ? txd_o : rxd_drv;

  always #5 clk = ~clk;

  uart_core #(.DATA_W(DATA_W), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .baud_div_i(baud_div_i), .len_i(len_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
    .loop_i(loop_i), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
    .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
    .rx_ready_i(rx_ready_i), .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
    .tx_busy_o(tx_busy_o), .err_parity_o(err_parity_o), .err_frame_o(err_frame_o),
    .err_overrun_o(err_overrun_o), .err_clr_i(err_clr_i), .rxd_i(rxd_line),
    .txd_o(txd_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit fbits[$];
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: word length clamp, parity rule and frame bit list.
  function automatic int eff_len(input int l);
    if (l < 5) return 5;
    if (l > DATA_W) return DATA_W;
    return l;
  endfunction

  function automatic int mask_of(input int l);
    return (1 << l) - 1;
  endfunction

  function automatic bit par_bit(input int d, input int l, input bit odd);
    int ones;
    ones = $countones(d & mask_of(l));
    return bit'(ones % 2) ^ odd;
  endfunction

  task automatic make_frame(input int d, input int l, input bit pen, input bit odd,
                            input bit s2, input bit flip, input bit stopv);
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < l; i++) fbits.push_back(bit'((d >> i) & 1));
    if (pen) fbits.push_back(par_bit(d, l, odd) ^ flip);
    fbits.push_back(stopv);
    if (s2) fbits.push_back(1'b1);
  endtask

  task automatic send_word(input int d);
    for (int i = 0; i < 100 && !tx_ready_o; i++) @(negedge clk);
    chk("tx_ready_before_write", tx_ready_o, 1);
    tx_valid_i = 1'b1;
    tx_data_i  = DATA_W'(d);
    @(negedge clk);
    tx_valid_i = 1'b0;
  endtask

  // Checks txd_o at the middle of every bit of the frame held in fbits.
  task automatic watch_tx();
    for (int i = 0; i < 300 && txd_o; i++) @(negedge clk);
    chk("tx_start_seen", txd_o, 0);
    chk("tx_busy_in_frame", tx_busy_o, 1);
    repeat (8) @(negedge clk);
    foreach (fbits[k]) begin
      chk($sformatf("txbit%0d", k), txd_o, fbits[k]);
      repeat (16) @(negedge clk);
    end
    chk("tx_busy_after_frame", tx_busy_o, 0);
  endtask

  task automatic drive_rx(input int d, input int l, input bit pen, input bit odd,
                          input bit flip, input bit stopv);
    make_frame(d, l, pen, odd, 1'b0, flip, stopv);
    foreach (fbits[k]) begin
      rxd_drv = fbits[k];
      repeat (16) @(negedge clk);
    end
    if (!stopv) repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic read_rx(input int exp, input string tag);
    for (int i = 0; i < 400 && !rx_valid_o; i++) @(negedge clk);
    chk({tag, "_valid"}, rx_valid_o, 1);
    chk({tag, "_data"}, rx_data_o, exp);
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
  endtask

  initial begin
    int d, l, le;
    bit pen, odd, s2;
    rst_i = 1'b0; baud_div_i = 16'd0; len_i = 4'd8; parity_en_i = 1'b0;
    parity_odd_i = 1'b0; stop2_i = 1'b0; loop_i = 1'b1; tx_valid_i = 1'b0;
    tx_data_i = '0; rx_ready_i = 1'b0; err_clr_i = 1'b0; rxd_drv = 1'b1; ext_loop = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", txd_o, 1);
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_tx_level", tx_level_o, 0);
    chk("rst_rx_level", rx_level_o, 0);
    chk("rst_busy", tx_busy_o, 0);
    chk("rst_errs", {err_parity_o, err_frame_o, err_overrun_o}, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 8N1 0xA5
    send_word(32'hA5);
    make_frame(32'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    watch_tx();
    read_rx(32'hA5, "lb_a5");

    // Random frame formats, including out-of-range len_i values
    for (int f = 0; f < 6; f++) begin
      l = int'($urandom_range(0, 15)); le = eff_len(l);
      pen = bit'($urandom_range(0, 1)); odd = bit'($urandom_range(0, 1));
      s2 = bit'($urandom_range(0, 1)); d = int'($urandom_range(0, 511));
      len_i = 4'(l); parity_en_i = pen; parity_odd_i = odd; stop2_i = s2;
      send_word(d);
      make_frame(d & mask_of(le), le, pen, odd, s2, 1'b0, 1'b1);
      watch_tx();
      read_rx(d & mask_of(le), $sformatf("lb_rand%0d", f));
      chk("lb_no_errs", {err_parity_o, err_frame_o, err_overrun_o}, 0);
    end

    // Parity: even parity on 0x07 transmits a 1 parity bit
    len_i = 4'd8; parity_en_i = 1'b1; parity_odd_i = 1'b0; stop2_i = 1'b0;
    send_word(32'h07);
    make_frame(32'h07, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("par_model_bit", fbits[9], 1);
    watch_tx();
    read_rx(32'h07, "par_lb");
    chk("par_lb_no_err", err_parity_o, 0);
    // Received frame with wrong parity is still delivered but flagged
    ext_loop = 1'b0;
    drive_rx(32'h07, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("par_err_set", err_parity_o, 1);
    read_rx(32'h07, "par_bad");
    pulse_clr();
    chk("par_err_clr", err_parity_o, 0);
    parity_en_i = 1'b0;

    // Glitch shorter than half a bit is ignored
    rxd_drv = 1'b0;
    repeat (5) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_rx_valid", rx_valid_o, 0);
    chk("glitch_errs", {err_parity_o, err_frame_o, err_overrun_o}, 0);

    // Frame error: stop bit sampled low, word dropped
    drive_rx(32'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("frm_err_set", err_frame_o, 1);
    chk("frm_rx_level", rx_level_o, 0);
    pulse_clr();
    chk("frm_err_clr", err_frame_o, 0);
    drive_rx(32'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    read_rx(32'h3C, "frm_recover");

    // Overrun: 17 frames without reading
    exp_q.delete();
    for (int f = 0; f < 17; f++) begin
      d = int'($urandom_range(0, 255));
      if (f < 16) exp_q.push_back(d);
      if (f == 16) chk("ovr_not_yet", err_overrun_o, 0);
      drive_rx(d, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("ovr_level", rx_level_o, 16);
    chk("ovr_flag", err_overrun_o, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr_word%0d", i), rx_data_o, exp_q[i]);
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
    end
    chk("ovr_drained", rx_level_o, 0);
    pulse_clr();

    // TX FIFO fill while the tick is stalled, then reset mid-frame
    baud_div_i = 16'hFFFF;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      tx_valid_i = 1'b1;
      tx_data_i  = DATA_W'(i + 1);
      @(negedge clk);
    end
    chk("full_level", tx_level_o, 16);
    chk("full_ready", tx_ready_o, 0);
    @(negedge clk);
    tx_valid_i = 1'b0;
    chk("full_no_extra", tx_level_o, 16);
    baud_div_i = 16'd0;
    for (int i = 0; i < 50 && txd_o; i++) @(negedge clk);
    chk("full_start", txd_o, 0);
    chk("full_level_after_pop", tx_level_o, 15);
    repeat (5) @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mid_txd", txd_o, 1);
    chk("rst_mid_tx_level", tx_level_o, 0);
    chk("rst_mid_rx_level", rx_level_o, 0);
    chk("rst_mid_busy", tx_busy_o, 0);
    chk("rst_mid_ready", tx_ready_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_txd", txd_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
